// File: rtl/clock_set_ctrl_if.sv
// Key/tick inputs and time/highlight outputs of the clock-setting controller.
// The bench drives through master; the controller uses slave.
interface clock_set_ctrl_if;
  logic       tick_1s;
  logic       key_mode;
  logic       key_inc;
  logic       key_dec;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [2:0] edit_sel;
  logic       blink;

  modport master (
    output tick_1s, key_mode, key_inc, key_dec,
    input  hour, minute, second, edit_sel, blink
  );

  modport slave (
    input  tick_1s, key_mode, key_inc, key_dec,
    output hour, minute, second, edit_sel, blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// RUN/SET time-keeping controller: key press edges, hold-to-repeat stepping,
// hour/minute/second registers and edit-field blink for the VGA clock.
module clock_set_ctrl #(
  parameter int HOLD_T   = 25_000_000,
  parameter int REPEAT_T = 5_000_000,
  parameter int BLINK_T  = 12_500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  clock_set_ctrl_if.slave   bus
);

  localparam int HOLD_W  = (HOLD_T  > 1) ? $clog2(HOLD_T)  : 1;
  localparam int BLINK_W = (BLINK_T > 1) ? $clog2(BLINK_T) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(HOLD_T - 1);
  localparam logic [HOLD_W-1:0]  HOLD_RELOAD = HOLD_W'(HOLD_T - REPEAT_T);
  localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_T - 1);

  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_e;

  state_e              state_q, state_d;
  logic [4:0]          hour_q, hour_d;
  logic [5:0]          minute_q, minute_d;
  logic [5:0]          second_q, second_d;
  logic                key_mode_dly_q, key_mode_dly_d;
  logic                key_inc_dly_q, key_inc_dly_d;
  logic                key_dec_dly_q, key_dec_dly_d;
  logic                arm_q, arm_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_q, blink_d;

  logic mode_press, inc_press, dec_press;
  logic inc_only, dec_only;
  logic step_up, step_dn;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] top);
    return (v == top) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] top);
    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  always_comb begin
    state_d        = state_q;
    hour_d         = hour_q;
    minute_d       = minute_q;
    second_d       = second_q;
    key_mode_dly_d = bus.key_mode;
    key_inc_dly_d  = bus.key_inc;
    key_dec_dly_d  = bus.key_dec;
    arm_d          = arm_q;
    hold_cnt_d     = hold_cnt_q;
    blink_cnt_d    = blink_cnt_q;
    blink_d        = blink_q;
    step_up        = 1'b0;
    step_dn        = 1'b0;

    mode_press = key_mode_dly_q & ~bus.key_mode;
    inc_press  = key_inc_dly_q  & ~bus.key_inc;
    dec_press  = key_dec_dly_q  & ~bus.key_dec;
    inc_only   = ~bus.key_inc &  bus.key_dec;
    dec_only   =  bus.key_inc & ~bus.key_dec;

    if (mode_press) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        default:  state_d = RUN;
      endcase
    end

    // Repeat is armed only by a fresh single-key press inside a set mode, so a
    // key still held across a mode change stays inert until re-pressed.
    if (state_q == RUN) begin
      arm_d      = 1'b0;
      hold_cnt_d = '0;
      if (bus.tick_1s) begin
        second_d = wrap_inc(second_q, 6'd59);
        if (second_q == 6'd59) begin
          minute_d = wrap_inc(minute_q, 6'd59);
          if (minute_q == 6'd59)
            hour_d = 5'(wrap_inc({1'b0, hour_q}, 6'd23));
        end
      end
    end else if (mode_press) begin
      arm_d      = 1'b0;
      hold_cnt_d = '0;
    end else if ((inc_press && inc_only) || (dec_press && dec_only)) begin
      arm_d      = 1'b1;
      hold_cnt_d = '0;
      step_up    = inc_press && inc_only;
      step_dn    = dec_press && dec_only;
    end else if (arm_q && (inc_only || dec_only)) begin
      if (hold_cnt_q == HOLD_LAST) begin
        hold_cnt_d = HOLD_RELOAD;
        step_up    = inc_only;
        step_dn    = dec_only;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end else begin
      arm_d      = 1'b0;
      hold_cnt_d = '0;
    end

    if (step_up) begin
      case (state_q)
        SET_HOUR: hour_d   = 5'(wrap_inc({1'b0, hour_q}, 6'd23));
        SET_MIN:  minute_d = wrap_inc(minute_q, 6'd59);
        SET_SEC:  second_d = wrap_inc(second_q, 6'd59);
        default:  ;
      endcase
    end else if (step_dn) begin
      case (state_q)
        SET_HOUR: hour_d   = 5'(wrap_dec({1'b0, hour_q}, 6'd23));
        SET_MIN:  minute_d = wrap_dec(minute_q, 6'd59);
        SET_SEC:  second_d = wrap_dec(second_q, 6'd59);
        default:  ;
      endcase
    end

    // Any edit activity restarts the blink phase visible so the field never
    // disappears right after the user touched it.
    if (state_d == RUN) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (mode_press || step_up || step_dn) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      hour_q         <= '0;
      minute_q       <= '0;
      second_q       <= '0;
      key_mode_dly_q <= 1'b1;
      key_inc_dly_q  <= 1'b1;
      key_dec_dly_q  <= 1'b1;
      arm_q          <= 1'b0;
      hold_cnt_q     <= '0;
      blink_cnt_q    <= '0;
      blink_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      hour_q         <= hour_d;
      minute_q       <= minute_d;
      second_q       <= second_d;
      key_mode_dly_q <= key_mode_dly_d;
      key_inc_dly_q  <= key_inc_dly_d;
      key_dec_dly_q  <= key_dec_dly_d;
      arm_q          <= arm_d;
      hold_cnt_q     <= hold_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_q        <= blink_d;
    end
  end

  always_comb begin
    case (state_q)
      SET_HOUR: bus.edit_sel = 3'b100;
      SET_MIN:  bus.edit_sel = 3'b010;
      SET_SEC:  bus.edit_sel = 3'b001;
      default:  bus.edit_sel = 3'b000;
    endcase
  end

  assign bus.hour   = hour_q;
  assign bus.minute = minute_q;
  assign bus.second = second_q;
  assign bus.blink  = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized and directed bench for clock_set_ctrl, checked against a
// seconds-of-day reference model with hold/blink timing kept as elapsed counts.
module tb_clock_set_ctrl;

  localparam int HOLD_T   = 10;
  localparam int REPEAT_T = 4;
  localparam int BLINK_T  = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(
    .HOLD_T  (HOLD_T),
    .REPEAT_T(REPEAT_T),
    .BLINK_T (BLINK_T)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time as seconds of day, mode as 0=RUN..3=SET_SEC,
  // hold as cycles held since the arming press, blink as cycles since last edit.
  int m_secs, m_state, m_held, m_hkey, m_since;
  bit mp, ip, dp;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_secs = 0; m_state = 0; m_held = -1; m_hkey = 0; m_since = 0;
    mp = 1'b1; ip = 1'b1; dp = 1'b1;
  endtask

  task automatic model_update(input bit t, input bit m, input bit i, input bit d);
    bit pm, pi, pd;
    int dir, h, mi, s;
    pm = mp & !m; pi = ip & !i; pd = dp & !d;
    dir = 0;
    if (m_state == 0) begin
      m_held = -1;
      if (t) m_secs = (m_secs + 1) % 86400;
    end else if (pm) begin
      m_held = -1;
    end else if (pi && d) begin
      dir = 1; m_held = 0; m_hkey = 1;
    end else if (pd && i) begin
      dir = -1; m_held = 0; m_hkey = -1;
    end else if (m_held >= 0 && ((m_hkey == 1 && !i && d) || (m_hkey == -1 && !d && i))) begin
      m_held++;
      if (m_held >= HOLD_T && (m_held - HOLD_T) % REPEAT_T == 0) dir = m_hkey;
    end else begin
      m_held = -1;
    end
    if (dir != 0) begin
      h = m_secs / 3600; mi = (m_secs / 60) % 60; s = m_secs % 60;
      case (m_state)
        1: h  = (h + dir + 24) % 24;
        2: mi = (mi + dir + 60) % 60;
        3: s  = (s + dir + 60) % 60;
        default: ;
      endcase
      m_secs = h * 3600 + mi * 60 + s;
    end
    if (pm) m_state = (m_state + 1) % 4;
    if (m_state == 0 || pm || dir != 0) m_since = 0;
    else m_since++;
    mp = m; ip = i; dp = d;
  endtask

  task automatic check_all();
    int unsigned es;
    es = (m_state == 1) ? 4 : (m_state == 2) ? 2 : (m_state == 3) ? 1 : 0;
    chk("hour",     bus.hour,     m_secs / 3600);
    chk("minute",   bus.minute,   (m_secs / 60) % 60);
    chk("second",   bus.second,   m_secs % 60);
    chk("edit_sel", bus.edit_sel, es);
    chk("blink",    bus.blink,    (m_state == 0) ? 0 : (((m_since / BLINK_T) % 2 == 0) ? 1 : 0));
  endtask

  task automatic cyc(input bit t, input bit m, input bit i, input bit d);
    @(negedge clk);
    bus.tick_1s = t; bus.key_mode = m; bus.key_inc = i; bus.key_dec = d;
    model_update(t, m, i, d);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // 0 = mode, 1 = inc, 2 = dec; one low cycle followed by one released cycle
  task automatic press(input int k);
    cyc(1'b0, k != 0, k != 1, k != 2);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.tick_1s = 1'b0; bus.key_mode = 1'b1; bus.key_inc = 1'b1; bus.key_dec = 1'b1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit rk_m, rk_i, rk_d;
    bus.tick_1s = 1'b0; bus.key_mode = 1'b1; bus.key_inc = 1'b1; bus.key_dec = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_hour",     bus.hour,     0);
    chk("rst_minute",   bus.minute,   0);
    chk("rst_second",   bus.second,   0);
    chk("rst_edit_sel", bus.edit_sel, 0);
    chk("rst_blink",    bus.blink,    0);
    rst_n = 1'b1;

    // Free-running time: 3661 s -> 01:01:01
    repeat (3661) cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t1_hour",   bus.hour,   1);
    chk("t1_minute", bus.minute, 1);
    chk("t1_second", bus.second, 1);
    chk("t1_sel",    bus.edit_sel, 0);
    chk("t1_blink",  bus.blink,  0);

    // Preload 23:59:59 with dec presses, then one tick rolls the day
    press(0);
    chk("t2_sel_hour", bus.edit_sel, 3'b100);
    press(2); press(2);
    press(0); press(2); press(2);
    press(0); press(2); press(2);
    press(0);
    chk("t2_pre_h", bus.hour,   23);
    chk("t2_pre_m", bus.minute, 59);
    chk("t2_pre_s", bus.second, 59);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t2_roll_h", bus.hour,   0);
    chk("t2_roll_m", bus.minute, 0);
    chk("t2_roll_s", bus.second, 0);

    // SET_HOUR: dec wraps 0 -> 23, ticks frozen
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t3_sel",   bus.edit_sel, 3'b100);
    chk("t3_blink", bus.blink,    1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    press(2);
    chk("t3_hour_wrap", bus.hour, 23);
    repeat (5) cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t3_sec_frozen", bus.second, 0);

    // SET_MIN auto-repeat from 58 up, then down
    press(0);
    press(2); press(2);
    chk("t4_min_start", bus.minute, 58);
    repeat (21) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("t4_min_up", bus.minute, 2);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (21) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4_min_down", bus.minute, 58);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);

    // SET_SEC: mode+inc together -> RUN with second untouched
    press(0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_sel_run",  bus.edit_sel, 0);
    chk("t5_sec_same", bus.second,   0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    press(0); press(0);
    repeat (50) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_both_min", bus.minute, 58);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);

    // Async reset mid-hold in SET_HOUR, mode key held across release
    press(0); press(0); press(0);
    chk("t6_sel_hour", bus.edit_sel, 3'b100);
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_h",   bus.hour,     0);
    chk("t6_async_m",   bus.minute,   0);
    chk("t6_async_s",   bus.second,   0);
    chk("t6_async_sel", bus.edit_sel, 0);
    chk("t6_async_bl",  bus.blink,    0);
    bus.key_mode = 1'b0; bus.key_inc = 1'b1; bus.key_dec = 1'b1; bus.tick_1s = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_one_press", bus.edit_sel, 3'b100);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);

    // Random key activity and ticks
    do_reset();
    rk_m = 1'b1; rk_i = 1'b1; rk_d = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 23) == 0) rk_m = ~rk_m;
      if ($urandom_range(0, 11) == 0) rk_i = ~rk_i;
      if ($urandom_range(0, 11) == 0) rk_d = ~rk_d;
      cyc($urandom_range(0, 3) == 0, rk_m, rk_i, rk_d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
